// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// segment bit positions, the hex glyph table and slot-length arithmetic.
package sevenseg_pkg;

    // Bit positions inside the 7-bit segment vector ([6]=a .. [0]=g).
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Shortest slot that still leaves room for the gap cycle plus a usable
    // 16-step brightness range.
    localparam int unsigned MIN_DIV = 16;

    typedef logic [6:0] seg_t;

    // Clock cycles per digit slot.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned digit_hz);
        if (digit_hz == 0) begin
            return 0;
        end
        return clk_hz / digit_hz;
    endfunction

    // Hex nibble to segment pattern, 1 = segment lit.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        seg = '0;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Update bus between the producer of display content and the scanner.
interface sevenseg_if #(
    parameter int NUM_DIGITS = 8
);
    // Handshake: load is a single-cycle capture strobe with no ready; the
    // scanner always accepts it. busy_pending is high from the cycle after a
    // capture until the frame boundary that makes it visible. A load in the
    // boundary cycle itself is applied at once and never raises busy_pending.
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [3:0]              brightness;
    logic                    load;
    logic                    busy_pending;

    modport master (
        output value,
        output dp,
        output digit_en,
        output blank_lz,
        output brightness,
        output load,
        input  busy_pending
    );

    modport slave (
        input  value,
        input  dp,
        input  digit_en,
        input  blank_lz,
        input  brightness,
        input  load,
        output busy_pending
    );

endinterface

// File: rtl/sevenseg_timebase.sv
// Slot counter and digit rotator for the scanner; also decodes the frame
// boundary and the PWM on-window of the current slot.
module sevenseg_timebase
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIV        = 16,
    parameter int          NUM_DIGITS = 8,
    parameter int          CW         = 4,
    parameter int          IW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    brightness,
    output logic [IW-1:0] digit_idx,
    output logic          frame_done,
    output logic          on_window
);

    logic [CW-1:0] slot_cnt;
    logic          slot_last;
    logic          idx_last;
    logic [31:0]   on_len;

    assign slot_last = (slot_cnt == CW'(DIV - 1));
    assign idx_last  = (digit_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= idx_last ? '0 : digit_idx + IW'(1);
        end else begin
            slot_cnt  <= slot_cnt + CW'(1);
        end
    end

    assign frame_done = slot_last && idx_last;

    // Count 0 is always dark so the previous digit's anode has fully turned
    // off before the next digit's segments appear; full brightness gives
    // on_len = DIV, i.e. lit for counts 1..DIV-1.
    assign on_len    = ((32'(brightness) + 32'd1) * DIV) >> 4;
    assign on_window = (slot_cnt != '0) && (32'(slot_cnt) <= on_len);

endmodule

// File: rtl/sevenseg_scanner.sv
// Multiplexed common-anode seven-segment driver with tear-free frame-boundary
// updates, per-digit enable, leading-zero blanking and PWM brightness.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int          NUM_DIGITS     = 8,
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned DIGIT_HZ       = 1000,
    parameter int          AN_ACTIVE_LOW  = 1,
    parameter int          SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sevenseg_if.slave             upd,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned DIV = calc_div(CLK_HZ, DIGIT_HZ);
    localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic        SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic        AN_INV  = (AN_ACTIVE_LOW != 0);

    if (DIV < MIN_DIV) begin : g_bad_div
        $error("sevenseg_scanner: CLK_HZ/DIGIT_HZ = %0d is below %0d", DIV, MIN_DIV);
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("sevenseg_scanner: NUM_DIGITS = %0d outside 1..16", NUM_DIGITS);
    end

    logic [IW-1:0] digit_idx;
    logic          on_window;

    sevenseg_timebase #(
        .DIV        (DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .CW         (CW),
        .IW         (IW)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (upd.brightness),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .on_window  (on_window)
    );

    // Staging holds the most recent load; active is what the scan shows.
    logic [4*NUM_DIGITS-1:0] value_s, value_a;
    logic [NUM_DIGITS-1:0]   dp_s, dp_a;
    logic [NUM_DIGITS-1:0]   en_s, en_a;
    logic                    blz_s, blz_a;
    logic                    busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_s <= '0;
            dp_s    <= '0;
            en_s    <= '0;
            blz_s   <= 1'b0;
            value_a <= '0;
            dp_a    <= '0;
            en_a    <= '0;
            blz_a   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (upd.load) begin
                value_s <= upd.value;
                dp_s    <= upd.dp;
                en_s    <= upd.digit_en;
                blz_s   <= upd.blank_lz;
            end
            if (frame_done) begin
                // A load landing on the boundary bypasses staging so it is
                // not held back a whole extra frame.
                if (upd.load) begin
                    value_a <= upd.value;
                    dp_a    <= upd.dp;
                    en_a    <= upd.digit_en;
                    blz_a   <= upd.blank_lz;
                end else begin
                    value_a <= value_s;
                    dp_a    <= dp_s;
                    en_a    <= en_s;
                    blz_a   <= blz_s;
                end
                busy_q <= 1'b0;
            end else if (upd.load) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign upd.busy_pending = busy_q;

    // Digit i is blanked when every nibble from i up to the top is zero.
    logic [NUM_DIGITS-1:0] lz;
    logic                  zero_run;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (value_a[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz[i] = blz_a && zero_run;
            end
        end
    end

    logic [3:0]            cur_nibble;
    logic                  lit;
    seg_t                  seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        cur_nibble = value_a[4*int'(digit_idx) +: 4];
        lit        = on_window && en_a[digit_idx] && !lz[digit_idx];
        seg_next   = '0;
        dp_next    = 1'b0;
        an_next    = '0;
        if (lit) begin
            seg_next = hex_to_seg(cur_nibble);
            dp_next  = dp_a[digit_idx];
            an_next  = NUM_DIGITS'(1) << digit_idx;
        end
    end

    // Polarity is applied at the flop so the pins come straight off registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= {7{SEG_INV}};
            dp_out  <= SEG_INV;
            an      <= {NUM_DIGITS{AN_INV}};
        end else begin
            seg_out <= seg_next ^ {7{SEG_INV}};
            dp_out  <= dp_next ^ SEG_INV;
            an      <= an_next ^ {NUM_DIGITS{AN_INV}};
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner: DIV=16, 8 digits, active-low outputs.
module tb_sevenseg_scanner;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [N-1:0] an;
    logic       frame_done;

    always #5 clk = ~clk;

    sevenseg_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_scanner #(
        .NUM_DIGITS     (N),
        .CLK_HZ         (1600),
        .DIGIT_HZ       (100),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd        (bus),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;
    int since_fd = 0;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic        blz;
        logic [3:0]  br;
        int          digit;
        int          cnt;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        since_fd++;
    endtask

    // Stops on the negedge where frame_done is seen; that is position zero.
    task automatic sync_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("frame_done_wait", {31'd0, frame_done}, 32'd1);
        since_fd = 0;
    endtask

    // Outputs sampled m = 2 + 16*digit + cnt negedges after frame_done reflect
    // that slot position of the new frame.
    task automatic goto_pos(input int digit, input int cnt);
        int m = 2 + 16 * digit + cnt;
        if (since_fd > m) check("goto_order", since_fd, m);
        while (since_fd < m) step();
    endtask

    task automatic load_vals(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e,
                             input logic b, input logic [3:0] br);
        if (frame_done === 1'b1) step();
        bus.value      = v;
        bus.dp         = d;
        bus.digit_en   = e;
        bus.blank_lz   = b;
        bus.brightness = br;
        bus.load       = 1'b1;
        step();
        bus.load       = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int torn;
        int lit5;
        int busy_hi;
        int dark_bad;
        int early_fd;

        vecs[0]  = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15, 0, 1,  8'hFE, 7'h42, 1'b1};
        vecs[1]  = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15, 0, 15, 8'hFE, 7'h42, 1'b1};
        vecs[2]  = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15, 0, 0,  8'hFF, 7'h7F, 1'b1};
        vecs[3]  = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15, 1, 5,  8'hFD, 7'h31, 1'b1};
        vecs[4]  = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15, 7, 8,  8'h7F, 7'h4F, 1'b1};
        vecs[5]  = '{32'h1234ABCD, 8'h04, 8'hFF, 1'b0, 4'd15, 2, 7,  8'hFB, 7'h60, 1'b0};
        vecs[6]  = '{32'h00000050, 8'h00, 8'hFF, 1'b1, 4'd15, 1, 3,  8'hFD, 7'h24, 1'b1};
        vecs[7]  = '{32'h00000050, 8'h00, 8'hFF, 1'b1, 4'd15, 0, 3,  8'hFE, 7'h01, 1'b1};
        vecs[8]  = '{32'h00000050, 8'h00, 8'hFF, 1'b1, 4'd15, 2, 3,  8'hFF, 7'h7F, 1'b1};
        vecs[9]  = '{32'h00000050, 8'h00, 8'hFF, 1'b1, 4'd15, 7, 3,  8'hFF, 7'h7F, 1'b1};
        vecs[10] = '{32'h00000000, 8'h01, 8'hFF, 1'b1, 4'd15, 0, 2,  8'hFE, 7'h01, 1'b0};
        vecs[11] = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 4'd15, 1, 2,  8'hFF, 7'h7F, 1'b1};
        vecs[12] = '{32'h00000000, 8'h00, 8'hFF, 1'b0, 4'd15, 5, 9,  8'hDF, 7'h01, 1'b1};
        vecs[13] = '{32'h0F000000, 8'h00, 8'hFF, 1'b1, 4'd15, 5, 9,  8'hDF, 7'h01, 1'b1};
        vecs[14] = '{32'h0F000000, 8'h00, 8'hFF, 1'b1, 4'd15, 6, 9,  8'hBF, 7'h38, 1'b1};
        vecs[15] = '{32'h0F000000, 8'h80, 8'hFF, 1'b1, 4'd15, 7, 9,  8'hFF, 7'h7F, 1'b1};
        vecs[16] = '{32'h88888888, 8'h00, 8'hFF, 1'b0, 4'd3,  3, 4,  8'hF7, 7'h00, 1'b1};
        vecs[17] = '{32'h88888888, 8'h00, 8'hFF, 1'b0, 4'd3,  3, 5,  8'hFF, 7'h7F, 1'b1};
        vecs[18] = '{32'h88888888, 8'h00, 8'hFF, 1'b0, 4'd3,  3, 1,  8'hF7, 7'h00, 1'b1};
        vecs[19] = '{32'h1234ABCD, 8'h00, 8'h0F, 1'b0, 4'd15, 4, 6,  8'hFF, 7'h7F, 1'b1};
        vecs[20] = '{32'h1234ABCD, 8'h00, 8'h0F, 1'b0, 4'd15, 3, 6,  8'hF7, 7'h08, 1'b1};
        vecs[21] = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd0,  2, 1,  8'hFB, 7'h60, 1'b1};
        vecs[22] = '{32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd0,  2, 2,  8'hFF, 7'h7F, 1'b1};

        bus.value = '0; bus.dp = '0; bus.digit_en = '0;
        bus.blank_lz = 1'b0; bus.brightness = 4'd15; bus.load = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_an", an, 32'hFF);
        check("rst_seg", seg_out, 32'h7F);
        check("rst_dp", dp_out, 32'd1);
        check("rst_fd", frame_done, 32'd0);
        check("rst_busy", bus.busy_pending, 32'd0);
        rst_n = 1'b1;

        // Frame boundary pulse width and period.
        sync_fd();
        step();
        check("fd_width", frame_done, 32'd0);
        while (frame_done !== 1'b1 && since_fd < 300) step();
        check("fd_period", since_fd, 32'd128);

        // Table of display vectors.
        for (int i = 0; i < NV; i++) begin
            load_vals(vecs[i].value, vecs[i].dp, vecs[i].en, vecs[i].blz, vecs[i].br);
            sync_fd();
            goto_pos(vecs[i].digit, vecs[i].cnt);
            check($sformatf("row%0d_an", i), an, vecs[i].exp_an);
            check($sformatf("row%0d_seg", i), seg_out, vecs[i].exp_seg);
            check($sformatf("row%0d_dp", i), dp_out, vecs[i].exp_dp);
        end

        // Two loads inside one frame: last wins, no torn frame.
        sync_fd();
        step();
        load_vals(32'hAAAAAAAA, 8'h00, 8'hFF, 1'b0, 4'd15);
        check("busy_after_load", bus.busy_pending, 32'd1);
        goto_pos(3, 0);
        load_vals(32'h55555555, 8'h00, 8'hFF, 1'b0, 4'd15);
        check("busy_after_reload", bus.busy_pending, 32'd1);
        sync_fd();
        check("busy_at_fd", bus.busy_pending, 32'd1);
        torn = 0;
        lit5 = 0;
        for (int m = 1; m <= 129; m++) begin
            step();
            if (m == 1) check("busy_cleared", bus.busy_pending, 32'd0);
            if (m >= 2 && seg_out == 7'h08) torn++;
            if (m >= 2 && an != 8'hFF && seg_out == 7'h24) lit5++;
        end
        check("torn_glyphs", torn, 32'd0);
        check("lit_fives", lit5, 32'd120);

        // Load coincident with frame_done goes straight to active.
        sync_fd();
        bus.value = 32'h77777777; bus.dp = 8'h00; bus.digit_en = 8'h0F;
        bus.blank_lz = 1'b0; bus.brightness = 4'd15; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        busy_hi = 0;
        for (int m = 1; m <= 129; m++) begin
            if (m > 1) step();
            if (bus.busy_pending === 1'b1) busy_hi++;
            if (since_fd == 3) begin
                check("coinc_d0_an", an, 32'hFE);
                check("coinc_d0_seg", seg_out, 32'h0F);
            end
            if (since_fd == 2 + 16 * 4 + 3) check("coinc_d4_dark", an, 32'hFF);
            if (since_fd == 2 + 16 * 7 + 5) check("coinc_d7_dark", an, 32'hFF);
        end
        check("coinc_busy_never", busy_hi, 32'd0);

        // Asynchronous reset in the middle of digit 5.
        load_vals(32'h1234ABCD, 8'h00, 8'hFF, 1'b0, 4'd15);
        sync_fd();
        goto_pos(5, 6);
        check("pre_rst_an", an, 32'hDF);
        check("pre_rst_seg", seg_out, 32'h06);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 32'hFF);
        check("async_rst_seg", seg_out, 32'h7F);
        check("async_rst_dp", dp_out, 32'd1);
        check("async_rst_fd", frame_done, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.load = 1'b1;
        dark_bad = 0;
        early_fd = 0;
        for (int k = 1; k <= 127; k++) begin
            step();
            bus.load = 1'b0;
            if (k == 1) check("post_rst_busy", bus.busy_pending, 32'd1);
            if (an != 8'hFF) dark_bad++;
            if (k < 127 && frame_done === 1'b1) early_fd++;
        end
        check("post_rst_dark", dark_bad, 32'd0);
        check("post_rst_early_fd", early_fd, 32'd0);
        check("post_rst_fd_at_127", frame_done, 32'd1);
        since_fd = 0;
        goto_pos(0, 0);
        check("post_rst_gap", an, 32'hFF);
        goto_pos(0, 1);
        check("post_rst_first_an", an, 32'hFE);
        check("post_rst_first_seg", seg_out, 32'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
